tone_lut_ctrl: RTL and testbench
================================

TONE_LUT_CTRL -- requirements
Module: tone_lut_ctrl

Interface
REQ-001 Parameter LUT_MAP_WTH, default 13: width of one tone-curve Y entry.
REQ-002 Parameter LUT_MAP_NUM, default 25: number of curve knots.
REQ-003 Parameter Y_DIFF_WTH, default 10: max bit width of adjacent-knot Y difference the tone datapath accepts.
REQ-004 Parameter ADDR_WTH, default 5: entry address width.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_wr_en  input  1  host write strobe into shadow bank.
REQ-008 i_wr_addr  input  ADDR_WTH  shadow entry index.
REQ-009 i_wr_data  input  LUT_MAP_WTH  shadow entry value.
REQ-010 i_rd_addr  input  ADDR_WTH  shadow readback index.
REQ-011 o_rd_data  output  LUT_MAP_WTH  registered shadow readback.
REQ-012 i_commit  input  1  pulse: request shadow -> active transfer.
REQ-013 i_vstr  input  1  frame-start pulse from video timing.
REQ-014 o_lut_data  output  LUT_MAP_WTH*LUT_MAP_NUM  active curve, entry k at bits [k*LUT_MAP_WTH +: LUT_MAP_WTH], drives tone datapath LUT bus.
REQ-015 o_busy  output  1  state != IDLE.
REQ-016 o_pend  output  1  state == PEND.
REQ-017 o_swap  output  1  one-cycle pulse when active bank updated.
REQ-018 o_wr_rej  output  1  one-cycle pulse: write dropped.
REQ-019 o_err  output  1  sticky curve-check error.

Function
REQ-020 Shadow bank SHALL hold LUT_MAP_NUM entries; active bank SHALL be a separate register set driving o_lut_data.
REQ-021 In IDLE, i_wr_en with i_wr_addr < LUT_MAP_NUM SHALL update shadow entry next cycle; addr >= LUT_MAP_NUM SHALL be dropped with o_wr_rej pulse next cycle.
REQ-022 i_wr_en in any state other than IDLE SHALL be dropped; o_wr_rej pulses next cycle.
REQ-023 o_rd_data SHALL equal shadow[i_rd_addr] one cycle after address; out-of-range address returns 0.
REQ-024 States: IDLE, CHECK, PEND; i_commit ignored outside IDLE.
REQ-025 IDLE + i_commit -> CHECK (macro on) or PEND (macro off), next cycle; simultaneous i_wr_en and i_commit: write applied, commit uses updated shadow.
REQ-026 PEND + i_vstr -> active := shadow, o_swap=1, state IDLE, all on the following edge; exactly one cycle of o_swap per transfer.
REQ-027 i_vstr in IDLE or CHECK SHALL have no effect; i_vstr in commit cycle SHALL NOT transfer.
REQ-028 Active bank SHALL never change except via REQ-026; o_lut_data stable for whole frame.
REQ-029 o_err SHALL clear on a commit accepted in IDLE.

Reset
REQ-030 On rst_n low: state IDLE, shadow and active entries 0, o_rd_data 0, o_busy/o_pend/o_swap/o_wr_rej/o_err 0, check counter 0.
REQ-031 Reset during CHECK or PEND SHALL abandon the commit; no transfer occurs after release until a new commit.

Configuration
REQ-032 Macro TONE_LUT_MONO_CHK_EN defined: CHECK state compiled in; counter k scans k=0..LUT_MAP_NUM-2, one pair per cycle, testing shadow[k+1] >= shadow[k] and shadow[k+1]-shadow[k] < 2^Y_DIFF_WTH.
REQ-033 With macro: any failing pair -> o_err=1, state IDLE next cycle, no transfer; all pass -> PEND after LUT_MAP_NUM-1 CHECK cycles (commit-to-o_pend latency LUT_MAP_NUM cycles, 25 default).
REQ-034 Without macro: no CHECK state, no counter, o_err tied 0; commit-to-o_pend latency 1 cycle.

Verification
REQ-035 Reset, write entry k = 40*k (k=0..24), commit, i_vstr after o_pend -> o_swap one cycle, o_lut_data entry 24 = 960, entry 0 = 0.
REQ-036 Write addr 25 in IDLE -> o_wr_rej pulse, shadow unchanged; write during PEND -> o_wr_rej, active after swap holds pre-PEND shadow.
REQ-037 Macro on: entry 10 = 500, entry 11 = 400, commit -> o_err=1 after scan, o_pend never asserted, i_vstr leaves o_lut_data unchanged.
REQ-038 Macro on: entry 5 = 0, entry 6 = 1024 (diff = 2^10), others monotonic -> o_err=1; diff 1023 -> pass, o_pend at commit+25.
REQ-039 i_vstr same cycle as i_commit -> no swap; next i_vstr in PEND -> swap.
REQ-040 rst_n low mid-CHECK at scan k=12 -> all outputs 0, later i_vstr causes no o_swap.

Source files
------------

// File: rtl/tone_lut_if.sv
// Host/video-timing bus for the tone-curve LUT controller: shadow write/readback,
// commit and frame-start handshake, plus the active curve and status outputs.
interface tone_lut_if #(
  parameter int LUT_MAP_WTH = 13,
  parameter int LUT_MAP_NUM = 25,
  parameter int ADDR_WTH    = 5
);
  logic                               i_wr_en;
  logic [ADDR_WTH-1:0]                i_wr_addr;
  logic [LUT_MAP_WTH-1:0]             i_wr_data;
  logic [ADDR_WTH-1:0]                i_rd_addr;
  logic [LUT_MAP_WTH-1:0]             o_rd_data;
  logic                               i_commit;
  logic                               i_vstr;
  logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0] o_lut_data;
  logic                               o_busy;
  logic                               o_pend;
  logic                               o_swap;
  logic                               o_wr_rej;
  logic                               o_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_commit, i_vstr,
    input  o_rd_data, o_lut_data, o_busy, o_pend, o_swap, o_wr_rej, o_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_commit, i_vstr,
    output o_rd_data, o_lut_data, o_busy, o_pend, o_swap, o_wr_rej, o_err
  );
endinterface

// File: rtl/tone_lut_ctrl.sv
// Double-buffered tone-curve LUT: host fills a shadow bank, a commit arms a frame-aligned
// copy into the active bank. Define TONE_LUT_MONO_CHK_EN to add the monotonic/slope scan.
//
//   state | meaning
//   IDLE  | shadow writable, waiting for commit
//   CHECK | scanning shadow pairs (TONE_LUT_MONO_CHK_EN only)
//   PEND  | curve accepted, waiting for i_vstr to swap banks
module tone_lut_ctrl #(
  parameter int LUT_MAP_WTH = 13,
  parameter int LUT_MAP_NUM = 25,
  parameter int Y_DIFF_WTH  = 10,
  parameter int ADDR_WTH    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  tone_lut_if.slave   bus
);
  localparam logic [ADDR_WTH:0] NUM_C = (ADDR_WTH+1)'(LUT_MAP_NUM);

`ifdef TONE_LUT_MONO_CHK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_PEND = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd2} state_t;
`endif

  state_t                             r_state;
  logic [LUT_MAP_WTH-1:0]             r_shadow [LUT_MAP_NUM];
  logic [LUT_MAP_WTH-1:0]             r_active [LUT_MAP_NUM];
  logic [LUT_MAP_WTH-1:0]             r_rd_data;
  logic                               r_busy;
  logic                               r_pend;
  logic                               r_swap;
  logic                               r_wr_rej;
  logic                               w_wr_ok;
  logic                               w_rd_ok;
  logic [LUT_MAP_WTH*LUT_MAP_NUM-1:0] w_lut_data;

  assign w_wr_ok = (r_state == S_IDLE) && ({1'b0, bus.i_wr_addr} < NUM_C);
  assign w_rd_ok = {1'b0, bus.i_rd_addr} < NUM_C;

`ifdef TONE_LUT_MONO_CHK_EN
  localparam logic [ADDR_WTH-1:0] LAST_K = ADDR_WTH'(LUT_MAP_NUM - 2);

  logic [ADDR_WTH-1:0]    r_cnt;
  logic                   r_err;
  logic [ADDR_WTH-1:0]    w_cnt_nxt;
  logic [LUT_MAP_WTH-1:0] w_lo;
  logic [LUT_MAP_WTH-1:0] w_hi;
  logic [LUT_MAP_WTH-1:0] w_diff;
  logic                   w_pair_ok;

  assign w_cnt_nxt = r_cnt + ADDR_WTH'(1);
  assign w_lo      = r_shadow[r_cnt];
  assign w_hi      = r_shadow[w_cnt_nxt];
  assign w_diff    = w_hi - w_lo;
  // Slope must fit the tone datapath's Y-difference field.
  assign w_pair_ok = (w_hi >= w_lo) &&
                     ({{(32-LUT_MAP_WTH){1'b0}}, w_diff} < (32'd1 << Y_DIFF_WTH));
  assign bus.o_err = r_err;
`else
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_pend    <= 1'b0;
      r_swap    <= 1'b0;
      r_wr_rej  <= 1'b0;
      for (int k = 0; k < LUT_MAP_NUM; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
`ifdef TONE_LUT_MONO_CHK_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_swap    <= 1'b0;
      r_wr_rej  <= bus.i_wr_en && !w_wr_ok;
      r_rd_data <= w_rd_ok ? r_shadow[bus.i_rd_addr] : '0;
      if (bus.i_wr_en && w_wr_ok) begin
        r_shadow[bus.i_wr_addr] <= bus.i_wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.i_commit) begin
            r_busy  <= 1'b1;
`ifdef TONE_LUT_MONO_CHK_EN
            r_state <= S_CHECK;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`else
            r_state <= S_PEND;
            r_pend  <= 1'b1;
`endif
          end
        end
`ifdef TONE_LUT_MONO_CHK_EN
        S_CHECK: begin
          if (!w_pair_ok) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_K) begin
            r_state <= S_PEND;
            r_pend  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= w_cnt_nxt;
          end
        end
`endif
        S_PEND: begin
          if (bus.i_vstr) begin
            for (int k = 0; k < LUT_MAP_NUM; k++) begin
              r_active[k] <= r_shadow[k];
            end
            r_swap  <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_lut_data = '0;
    for (int k = 0; k < LUT_MAP_NUM; k++) begin
      w_lut_data[k*LUT_MAP_WTH +: LUT_MAP_WTH] = r_active[k];
    end
  end

  assign bus.o_lut_data = w_lut_data;
  assign bus.o_rd_data  = r_rd_data;
  assign bus.o_busy     = r_busy;
  assign bus.o_pend     = r_pend;
  assign bus.o_swap     = r_swap;
  assign bus.o_wr_rej   = r_wr_rej;
endmodule

// File: tb/tb_tone_lut_ctrl.sv
// Self-checking bench for tone_lut_ctrl; follows TONE_LUT_MONO_CHK_EN when defined.
`timescale 1ns/1ps
module tb_tone_lut_ctrl;
  localparam int W  = 13;
  localparam int N  = 25;
  localparam int YD = 10;
  localparam int AW = 5;
`ifdef TONE_LUT_MONO_CHK_EN
  localparam bit CHK_ON = 1'b1;
  localparam int LAT    = N;
`else
  localparam bit CHK_ON = 1'b0;
  localparam int LAT    = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_lut_if #(.LUT_MAP_WTH(W), .LUT_MAP_NUM(N), .ADDR_WTH(AW)) bus ();

  tone_lut_ctrl #(.LUT_MAP_WTH(W), .LUT_MAP_NUM(N), .Y_DIFF_WTH(YD), .ADDR_WTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sh [N];
  int act [N];
  bit m_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit curve_ok();
    for (int k = 0; k < N - 1; k++)
      if (sh[k+1] < sh[k] || sh[k+1] - sh[k] >= (1 << YD)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_active(input string tag);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_e%0d", tag, k), 32'(bus.o_lut_data[k*W +: W]), act[k]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_pend"}, 32'(bus.o_pend), 0);
    check({tag, "_swap"}, 32'(bus.o_swap), 0);
    check({tag, "_rej"},  32'(bus.o_wr_rej), 0);
    check({tag, "_err"},  32'(bus.o_err), 0);
    check({tag, "_rd"},   32'(bus.o_rd_data), 0);
  endtask

  task automatic wr(input int a, input int d);
    bit acc;
    acc = m_idle && (a < N);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a[AW-1:0];
    bus.i_wr_data = d[W-1:0];
    step();
    bus.i_wr_en = 1'b0;
    check($sformatf("wr_rej_a%0d", a), 32'(bus.o_wr_rej), {31'd0, !acc});
    if (acc) sh[a] = d;
  endtask

  task automatic rd(input int a);
    bus.i_rd_addr = a[AW-1:0];
    step();
    check($sformatf("rd_a%0d", a), 32'(bus.o_rd_data), (a < N) ? sh[a] : 0);
  endtask

  task automatic load(input int c [N]);
    for (int k = 0; k < N; k++) wr(k, c[k]);
  endtask

  // Commit (optionally with a simultaneous write and/or i_vstr) and wait for the outcome.
  task automatic commit_run(input bit vstr_too, input bit do_wr, input int a, input int d);
    bit exp_pass;
    int lat;
    bus.i_commit  = 1'b1;
    bus.i_vstr    = vstr_too;
    bus.i_wr_en   = do_wr;
    bus.i_wr_addr = a[AW-1:0];
    bus.i_wr_data = d[W-1:0];
    if (do_wr) sh[a] = d;
    exp_pass = !CHK_ON || curve_ok();
    step();
    bus.i_commit = 1'b0;
    bus.i_vstr   = 1'b0;
    bus.i_wr_en  = 1'b0;
    m_idle = 1'b0;
    check("commit_swap", 32'(bus.o_swap), 0);
    check("commit_err_clr", 32'(bus.o_err), 0);
    check("commit_busy", 32'(bus.o_busy), 1);
    lat = 1;
    while (bus.o_busy === 1'b1 && bus.o_pend !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    if (exp_pass) begin
      check("pend_latency", lat, LAT);
      check("pend_set", 32'(bus.o_pend), 1);
    end else begin
      check("err_set", 32'(bus.o_err), 1);
      check("err_no_pend", 32'(bus.o_pend), 0);
      check("err_idle", 32'(bus.o_busy), 0);
      m_idle = 1'b1;
    end
  endtask

  task automatic vstr_swap(input int pre_wait);
    for (int i = 0; i < pre_wait; i++) begin
      step();
      check("pend_hold", 32'(bus.o_pend), 1);
    end
    check_active("pre_swap");
    bus.i_vstr = 1'b1;
    step();
    bus.i_vstr = 1'b0;
    check("swap", 32'(bus.o_swap), 1);
    check("swap_busy", 32'(bus.o_busy), 0);
    check("swap_pend", 32'(bus.o_pend), 0);
    act = sh;
    m_idle = 1'b1;
    step();
    check("swap_one_cycle", 32'(bus.o_swap), 0);
    check_active("post_swap");
  endtask

  task automatic vstr_idle(input string tag);
    bus.i_vstr = 1'b1;
    step();
    bus.i_vstr = 1'b0;
    check({tag, "_noswap"}, 32'(bus.o_swap), 0);
    step();
    check({tag, "_noswap2"}, 32'(bus.o_swap), 0);
    check_active(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c [N];
    int base;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_addr = '0; bus.i_commit = 1'b0; bus.i_vstr = 1'b0;
    for (int k = 0; k < N; k++) begin sh[k] = 0; act[k] = 0; end

    // Reset state
    repeat (3) step();
    check_quiet("rst");
    check_active("rst_lut");
    rst_n = 1'b1;
    step();
    check_quiet("post_rst");

    // Linear 40*k curve end to end
    for (int k = 0; k < N; k++) c[k] = 40 * k;
    load(c);
    rd(0); rd(24); rd(12); rd(25); rd(31);
    commit_run(1'b0, 1'b0, 0, 0);
    vstr_swap(2);
    check("e24_960", 32'(bus.o_lut_data[24*W +: W]), 960);
    check("e0_0", 32'(bus.o_lut_data[0 +: W]), 0);

    // Out-of-range write, then write while pending
    wr(25, 77);
    wr(31, 55);
    rd(24);
    vstr_idle("idle_vstr");
    for (int k = 0; k < N; k++) c[k] = 1000 + 30 * k;
    load(c);
    commit_run(1'b0, 1'b0, 0, 0);
    wr(3, 999);
    rd(3);
    vstr_swap(1);

    // i_vstr in the commit cycle must not swap; write+commit uses new data
    commit_run(1'b1, 1'b1, 24, sh[23] + 100);
    vstr_swap(0);

    // Randomized monotonic curves
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, 100);
      for (int k = 0; k < N; k++) begin
        c[k] = base;
        base = base + $urandom_range(0, 300);
      end
      load(c);
      for (int r = 0; r < 3; r++) rd($urandom_range(0, 31));
      vstr_idle("rnd_idle");
      commit_run($urandom_range(0, 1), 1'b1, 24, sh[23] + $urandom_range(0, 300));
      wr($urandom_range(0, 31), $urandom_range(0, 8191));
      vstr_swap($urandom_range(0, 3));
    end

`ifdef TONE_LUT_MONO_CHK_EN
    // Non-monotonic pair 10/11
    for (int k = 0; k < N; k++) c[k] = 40 * k;
    load(c);
    wr(10, 500);
    wr(11, 400);
    commit_run(1'b0, 1'b0, 0, 0);
    vstr_idle("nonmono_vstr");
    check("err_sticky", 32'(bus.o_err), 1);

    // Slope of exactly 2^10 fails, 2^10-1 passes
    for (int k = 0; k < N; k++) c[k] = (k <= 5) ? 0 : 1024 + 40 * (k - 6);
    load(c);
    commit_run(1'b0, 1'b0, 0, 0);
    for (int k = 0; k < N; k++) c[k] = (k <= 5) ? 0 : 1023 + 40 * (k - 6);
    load(c);
    commit_run(1'b0, 1'b0, 0, 0);
    vstr_swap(1);
`endif

    // Reset in the middle of the commit (scan index 12 when checking is built in)
    bus.i_commit = 1'b1;
    step();
    bus.i_commit = 1'b0;
    repeat (12) step();
    check("pre_rst_busy", 32'(bus.o_busy), 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin sh[k] = 0; act[k] = 0; end
    m_idle = 1'b1;
    check_quiet("mid_rst");
    check_active("mid_rst_lut");
    step();
    rst_n = 1'b1;
    step();
    vstr_idle("rst_vstr");
    check_quiet("rst_after");
    rd(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
